// File: rtl/rf_wb_queue.sv
// rf_wb_queue
// -----------------------------------------------------------------------------
// Write-back queue that sits in front of the register file write port.
// Pipeline producers push {destination, data} pairs through a valid/ready
// handshake. The queue buffers up to DEPTH of them and retires at most one per
// clock into the registered write port (write / WR / WD).
//
// The lookup ports tell decode whether a register it is reading still has a
// write pending. A pending write is either a queued entry or the value sitting
// in the output register, because the register file has not committed it yet.
//
// Optional feature macro: RF_WB_FWD_EN
//   When it is defined, fwd1/fwd2 carry the youngest pending data for PR1/PR2,
//   so decode can bypass instead of stalling. When it is undefined those ports
//   do not exist, and decode must stall whenever hz1/hz2 is set.
//
// Parameters
//   DEPTH : number of FIFO entries (power of two, >= 2)
//   DW    : data width
//   AW    : register address width
//
// Ports
//   clk            rising-edge clock
//   reset          synchronous active-low reset
//   in_valid       producer has a result
//   in_ready       queue can accept (combinational)
//   in_WR/in_WD    destination register / result data
//   hold           suppress draining this cycle (write port borrowed)
//   write/WR/WD    registered register file write port
//   PR1/PR2        register file read addresses being looked up
//   hz1/hz2        a write to PR1/PR2 is still pending (combinational)
//   fwd1/fwd2      youngest pending data for PR1/PR2 (RF_WB_FWD_EN only)
//   count          number of occupied FIFO entries
// -----------------------------------------------------------------------------
module rf_wb_queue #(
  parameter int DEPTH = 4,
  parameter int DW    = 32,
  parameter int AW    = 5
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [AW-1:0]            in_WR,
  input  logic [DW-1:0]            in_WD,
  input  logic                     hold,
  output logic                     write,
  output logic [AW-1:0]            WR,
  output logic [DW-1:0]            WD,
  input  logic [AW-1:0]            PR1,
  input  logic [AW-1:0]            PR2,
  output logic                     hz1,
  output logic                     hz2,
`ifdef RF_WB_FWD_EN
  output logic [DW-1:0]            fwd1,
  output logic [DW-1:0]            fwd2,
`endif
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  // FIFO storage and pointers. Both pointers are PW bits wide, so they wrap
  // modulo DEPTH on their own because DEPTH is a power of two.
  logic [AW-1:0] mem_addr [DEPTH];
  logic [DW-1:0] mem_data [DEPTH];
  logic [PW-1:0] head;
  logic [PW-1:0] tail;

  logic push;
  logic pop;

  // The queue only accepts while it is out of reset and has a free slot. There
  // is deliberately no bypass on full, even when a pop happens on the same
  // edge. This keeps in_ready independent of hold.
  assign in_ready = reset && (count < CW'(DEPTH));

  // A handshake for register 0 completes but stores nothing. Writes to the
  // zero register have no effect, so they never need to reach the port.
  assign push = in_valid && in_ready && (in_WR != '0);

  // Drain whenever something is queued and the port is not borrowed. An entry
  // pushed on this edge cannot pop on the same edge, because count only
  // reflects entries that were already stored.
  assign pop = (count != '0) && !hold;

  // Entry storage is not reset. Entries are only ever read when they are
  // inside the head..count window, so stale contents are never visible.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_addr[tail] <= in_WR;
      mem_data[tail] <= in_WD;
    end
  end

  // Pointer, occupancy and output-register state. Reset drops every queued
  // entry together with any write that is in flight in the output register.
  // When nothing pops, WR/WD keep their last value and only write drops.
  always_ff @(posedge clk) begin
    if (!reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      write <= 1'b0;
      WR    <= '0;
      WD    <= '0;
    end else begin
      if (push) begin
        tail <= tail + 1'b1;
      end
      if (pop) begin
        write <= 1'b1;
        WR    <= mem_addr[head];
        WD    <= mem_data[head];
        head  <= head + 1'b1;
      end else begin
        write <= 1'b0;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Hazard lookup across the output register and every live FIFO entry.
  // The scan goes from oldest to youngest: output register first, then the
  // entries from head onward. Each later match overwrites the forward value,
  // so the youngest matching write wins. Register 0 never reports a hazard.
  always_comb begin
    hz1 = 1'b0;
    hz2 = 1'b0;
`ifdef RF_WB_FWD_EN
    fwd1 = '0;
    fwd2 = '0;
`endif
    if (write) begin
      if (WR == PR1) begin
        hz1 = 1'b1;
`ifdef RF_WB_FWD_EN
        fwd1 = WD;
`endif
      end
      if (WR == PR2) begin
        hz2 = 1'b1;
`ifdef RF_WB_FWD_EN
        fwd2 = WD;
`endif
      end
    end
    for (int i = 0; i < DEPTH; i++) begin
      logic [PW-1:0] idx;
      idx = head + PW'(i);
      if (CW'(i) < count) begin
        if (mem_addr[idx] == PR1) begin
          hz1 = 1'b1;
`ifdef RF_WB_FWD_EN
          fwd1 = mem_data[idx];
`endif
        end
        if (mem_addr[idx] == PR2) begin
          hz2 = 1'b1;
`ifdef RF_WB_FWD_EN
          fwd2 = mem_data[idx];
`endif
        end
      end
    end
    if (PR1 == '0) begin
      hz1 = 1'b0;
`ifdef RF_WB_FWD_EN
      fwd1 = '0;
`endif
    end
    if (PR2 == '0) begin
      hz2 = 1'b0;
`ifdef RF_WB_FWD_EN
      fwd2 = '0;
`endif
    end
  end

endmodule

// File: tb/tb_rf_wb_queue.sv
// tb_rf_wb_queue
// -----------------------------------------------------------------------------
// Directed bench for rf_wb_queue with DEPTH=4, DW=32 and AW=5. Inputs change
// 1 time unit after a rising edge. Outputs are sampled after that, well away
// from the next edge. The forward checks are only compiled when RF_WB_FWD_EN
// is defined.
// -----------------------------------------------------------------------------
module tb_rf_wb_queue;

  localparam int DEPTH = 4;
  localparam int DW    = 32;
  localparam int AW    = 5;

  logic          clk;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [AW-1:0] in_WR;
  logic [DW-1:0] in_WD;
  logic          hold;
  logic          write;
  logic [AW-1:0] WR;
  logic [DW-1:0] WD;
  logic [AW-1:0] PR1;
  logic [AW-1:0] PR2;
  logic          hz1;
  logic          hz2;
`ifdef RF_WB_FWD_EN
  logic [DW-1:0] fwd1;
  logic [DW-1:0] fwd2;
`endif
  logic [$clog2(DEPTH):0] count;

  int checks = 0;
  int errors = 0;

  rf_wb_queue #(.DEPTH(DEPTH), .DW(DW), .AW(AW)) dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_WR    (in_WR),
    .in_WD    (in_WD),
    .hold     (hold),
    .write    (write),
    .WR       (WR),
    .WD       (WD),
    .PR1      (PR1),
    .PR2      (PR2),
    .hz1      (hz1),
    .hz2      (hz2),
`ifdef RF_WB_FWD_EN
    .fwd1     (fwd1),
    .fwd2     (fwd2),
`endif
    .count    (count)
  );

  // 10-unit clock period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance past the next rising edge. Registered outputs are then stable.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive the producer side of the handshake.
  task automatic applyStimulus(input logic v, input logic [AW-1:0] wr, input logic [DW-1:0] wd);
    in_valid = v;
    in_WR    = wr;
    in_WD    = wd;
  endtask

  // One counted comparison.
  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Directed sequence that walks through every feature of the queue.
  initial begin
    reset = 1'b0;
    hold  = 1'b0;
    PR1   = '0;
    PR2   = '0;
    applyStimulus(1'b0, '0, '0);

    // Hold reset low for two edges.
    tick();
    tick();
    checkOutput("rst_count", 64'(count), 64'd0);
    checkOutput("rst_write", 64'(write), 64'd0);
    checkOutput("rst_WR", 64'(WR), 64'd0);
    checkOutput("rst_WD", 64'(WD), 64'd0);
    checkOutput("rst_in_ready", 64'(in_ready), 64'd0);
    checkOutput("rst_hz1", 64'(hz1), 64'd0);
    reset = 1'b1;
    #1;
    checkOutput("post_rst_ready", 64'(in_ready), 64'd1);

    // Single push of {4,31}. It retires one edge after the push edge, and
    // the hazard stays up until the output register has been committed.
    applyStimulus(1'b1, 5'd4, 32'd31);
    PR1 = 5'd4;
    #1;
    checkOutput("t1_hz1_before", 64'(hz1), 64'd0);
    tick();
    applyStimulus(1'b0, '0, '0);
    checkOutput("t1_count1", 64'(count), 64'd1);
    checkOutput("t1_write_q", 64'(write), 64'd0);
    checkOutput("t1_hz1_queued", 64'(hz1), 64'd1);
    tick();
    checkOutput("t1_write", 64'(write), 64'd1);
    checkOutput("t1_WR", 64'(WR), 64'd4);
    checkOutput("t1_WD", 64'(WD), 64'd31);
    checkOutput("t1_count0", 64'(count), 64'd0);
    checkOutput("t1_hz1_outreg", 64'(hz1), 64'd1);
    tick();
    checkOutput("t1_write_off", 64'(write), 64'd0);
    checkOutput("t1_WR_hold", 64'(WR), 64'd4);
    checkOutput("t1_hz1_after", 64'(hz1), 64'd0);
    PR1 = '0;

    // Fill the queue under hold, try a fifth push, then drain it in order.
    hold = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      applyStimulus(1'b1, AW'(i), DW'(i * 10));
      tick();
      checkOutput("t2_fill_count", 64'(count), 64'(i));
      checkOutput("t2_fill_write", 64'(write), 64'd0);
    end
    checkOutput("t2_full_ready", 64'(in_ready), 64'd0);
    applyStimulus(1'b1, 5'd5, 32'd50);
    tick();
    checkOutput("t2_fifth_count", 64'(count), 64'd4);
    applyStimulus(1'b0, '0, '0);
    hold = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      tick();
      checkOutput("t2_drain_write", 64'(write), 64'd1);
      checkOutput("t2_drain_WR", 64'(WR), 64'(i));
      checkOutput("t2_drain_WD", 64'(WD), 64'(i * 10));
      checkOutput("t2_drain_count", 64'(count), 64'(4 - i));
      checkOutput("t2_drain_ready", 64'(in_ready), 64'd1);
    end
    tick();
    checkOutput("t2_idle_write", 64'(write), 64'd0);

    // Two writes to register 7. The youngest value is the one forwarded.
    hold = 1'b1;
    applyStimulus(1'b1, 5'd7, 32'd5);
    tick();
    applyStimulus(1'b1, 5'd7, 32'd9);
    tick();
    applyStimulus(1'b0, '0, '0);
    PR2 = 5'd7;
    #1;
    checkOutput("t3_hz2", 64'(hz2), 64'd1);
    checkOutput("t3_hz1_pr0", 64'(hz1), 64'd0);
`ifdef RF_WB_FWD_EN
    checkOutput("t3_fwd2", 64'(fwd2), 64'd9);
    checkOutput("t3_fwd1_zero", 64'(fwd1), 64'd0);
`endif
    hold = 1'b0;
    tick();
    checkOutput("t3_ret1_WD", 64'(WD), 64'd5);
    checkOutput("t3_ret1_hz2", 64'(hz2), 64'd1);
`ifdef RF_WB_FWD_EN
    checkOutput("t3_ret1_fwd2", 64'(fwd2), 64'd9);
`endif
    tick();
    checkOutput("t3_ret2_WD", 64'(WD), 64'd9);
    checkOutput("t3_ret2_hz2", 64'(hz2), 64'd1);
`ifdef RF_WB_FWD_EN
    checkOutput("t3_ret2_fwd2", 64'(fwd2), 64'd9);
`endif
    tick();
    checkOutput("t3_done_hz2", 64'(hz2), 64'd0);
`ifdef RF_WB_FWD_EN
    checkOutput("t3_done_fwd2", 64'(fwd2), 64'd0);
`endif
    PR2 = '0;

    // A push to register 0 completes the handshake but stores nothing.
    applyStimulus(1'b1, 5'd0, 32'd123);
    #1;
    checkOutput("t4_ready", 64'(in_ready), 64'd1);
    tick();
    applyStimulus(1'b0, '0, '0);
    checkOutput("t4_count", 64'(count), 64'd0);
    checkOutput("t4_write_a", 64'(write), 64'd0);
    tick();
    checkOutput("t4_write_b", 64'(write), 64'd0);
    checkOutput("t4_hz1", 64'(hz1), 64'd0);

    // Reset in the middle of operation drops every queued entry.
    hold = 1'b1;
    applyStimulus(1'b1, 5'd3, 32'd33);
    tick();
    applyStimulus(1'b1, 5'd5, 32'd55);
    tick();
    applyStimulus(1'b1, 5'd6, 32'd66);
    tick();
    applyStimulus(1'b0, '0, '0);
    PR1 = 5'd5;
    PR2 = 5'd6;
    #1;
    checkOutput("t5_count3", 64'(count), 64'd3);
    checkOutput("t5_hz1_pre", 64'(hz1), 64'd1);
    checkOutput("t5_hz2_pre", 64'(hz2), 64'd1);
    reset = 1'b0;
    hold  = 1'b0;
    tick();
    checkOutput("t5_count0", 64'(count), 64'd0);
    checkOutput("t5_write", 64'(write), 64'd0);
    checkOutput("t5_hz1", 64'(hz1), 64'd0);
    checkOutput("t5_hz2", 64'(hz2), 64'd0);
    checkOutput("t5_ready_rst", 64'(in_ready), 64'd0);
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput("t5_no_stale", 64'(write), 64'd0);
      checkOutput("t5_count_after", 64'(count), 64'd0);
    end
    PR1 = '0;
    PR2 = '0;

    // Streaming: one push per cycle, each entry retires one edge later.
    for (int i = 0; i < 12; i++) begin
      applyStimulus(1'b1, AW'(8 + i), DW'(100 + i));
      tick();
      checkOutput("t6_count", 64'(count), 64'd1);
      if (i > 0) begin
        checkOutput("t6_write", 64'(write), 64'd1);
        checkOutput("t6_WR", 64'(WR), 64'(8 + i - 1));
        checkOutput("t6_WD", 64'(WD), 64'(100 + i - 1));
      end
    end
    applyStimulus(1'b0, '0, '0);
    tick();
    checkOutput("t6_last_write", 64'(write), 64'd1);
    checkOutput("t6_last_WR", 64'(WR), 64'd19);
    checkOutput("t6_last_WD", 64'(WD), 64'd111);
    checkOutput("t6_empty", 64'(count), 64'd0);
    tick();
    checkOutput("t6_idle", 64'(write), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
